// File: rtl/mul_ucode_seq_if.sv
// mul_ucode_seq_if: decoder-to-multiply-sequencer request and writeback bundle
interface mul_ucode_seq_if #(parameter int DATA_W = 32);
  logic              mul_trigger;
  logic [1:0]        mul_type;
  logic              set_flags;
  logic [3:0]        dest_reg;
  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;
  logic [15:0]       imm;
  logic              flush;
  logic              stall;
  logic              wb_en;
  logic [3:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] prod_hi;
  logic              flag_wr;
  logic              flag_n;
  logic              flag_z;
  modport master (
    output mul_trigger, mul_type, set_flags, dest_reg, src1_data, src2_data, imm, flush,
    input  stall, wb_en, wb_reg, wb_data, prod_hi, flag_wr, flag_n, flag_z
  );
  modport slave (
    input  mul_trigger, mul_type, set_flags, dest_reg, src1_data, src2_data, imm, flush,
    output stall, wb_en, wb_reg, wb_data, prod_hi, flag_wr, flag_n, flag_z
  );
endinterface

// File: rtl/mul_ucode_seq.sv
// mul_ucode_seq: radix-2 shift-add multiply sequencer with single writeback and flag update
module mul_ucode_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic clk,
  input logic rst,
  mul_ucode_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, mcand, mplier;
  logic                sign, sf_q;
  logic                is_s;
  logic [DATA_W-1:0]   op_b, mag_a, mag_b;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  // operand selection, magnitudes, partial-sum adder and final sign fix
  always_comb begin
    is_s  = bus.mul_type[1];
    op_b  = bus.mul_type[0] ? bus.src2_data
          : is_s ? {{(DATA_W-16){bus.imm[15]}}, bus.imm} : {{(DATA_W-16){1'b0}}, bus.imm};
    mag_a = (is_s & bus.src1_data[DATA_W-1]) ? -bus.src1_data : bus.src1_data;
    mag_b = (is_s & op_b[DATA_W-1]) ? -op_b : op_b;
    sum   = {1'b0, acc_hi} + (mcand[0] ? {1'b0, mplier} : '0);
    prod  = sign ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  end
  assign bus.stall = (state == CALC) | (state == FIX) | ((state == IDLE) & bus.mul_trigger);
  // sequencer FSM with registered writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      mcand       <= '0;
      mplier      <= '0;
      sign        <= 1'b0;
      sf_q        <= 1'b0;
      bus.wb_en   <= 1'b0;
      bus.wb_reg  <= '0;
      bus.wb_data <= '0;
      bus.prod_hi <= '0;
      bus.flag_wr <= 1'b0;
      bus.flag_n  <= 1'b0;
      bus.flag_z  <= 1'b0;
    end else begin
      bus.wb_en   <= 1'b0;
      bus.flag_wr <= 1'b0;
      case (state)
        IDLE: if (bus.mul_trigger && !bus.flush) begin
          state      <= CALC;
          cnt        <= '0;
          acc_hi     <= '0;
          acc_lo     <= '0;
          mcand      <= mag_a;
          mplier     <= mag_b;
          sign       <= is_s & (bus.src1_data[DATA_W-1] ^ op_b[DATA_W-1]);
          sf_q       <= bus.set_flags;
          bus.wb_reg <= bus.dest_reg;
        end
        CALC: if (bus.flush) state <= IDLE;
        else begin
          acc_hi <= sum[DATA_W:1];
          acc_lo <= {sum[0], acc_lo[DATA_W-1:1]};
          mcand  <= mcand >> 1;
          cnt    <= cnt + 1'b1;
          state  <= (cnt == CNT_W'(DATA_W-1)) ? FIX : CALC;
        end
        FIX: if (bus.flush) state <= IDLE;
        else begin
          state       <= WB;
          bus.wb_en   <= 1'b1;
          bus.wb_data <= prod[DATA_W-1:0];
          bus.prod_hi <= prod[2*DATA_W-1:DATA_W];
          bus.flag_wr <= sf_q;
          bus.flag_n  <= prod[DATA_W-1];
          bus.flag_z  <= prod[DATA_W-1:0] == '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
